// File: rtl/controle_pkg.sv
// rtl/controle_pkg.sv - shared op encodings, state type and cycle defaults for the MULT/DIV sequencer
package controle_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        WRITE = 2'b10,
        EXC   = 2'b11
    } state_t;

    localparam int DEFAULT_MULT_CYCLES = 32;
    localparam int DEFAULT_DIV_CYCLES  = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/contador_ciclos.sv
// rtl/contador_ciclos.sv - loadable down-counter that saturates at zero
module contador_ciclos #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load has priority over clear and decrement; decrement stops at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (clear) begin
            count <= '0;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/controle_multdiv.sv
// rtl/controle_multdiv.sv - MULT/DIV sequencer with start/busy/done handshake, abort and div-by-zero exception
module controle_multdiv
    import controle_pkg::*;
#(
    parameter  int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter  int DIV_CYCLES  = DEFAULT_DIV_CYCLES,
    localparam int CNT_W       = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             divisor_zero,
    input  logic             abort,
    output logic             busy,
    output logic             mult_op,
    output logic             div_op,
    output logic             signed_op,
    output logic             reg_hi_write,
    output logic             reg_lo_write,
    output logic             mux_hi,
    output logic             mux_lo,
    output logic             done,
    output logic             div_zero_exc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t state;
    logic   op_div;
    logic   start_div;
    logic   accept_run;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_clear;
    logic   cnt_zero;

    assign start_div  = (op == OP_DIV) || (op == OP_DIVU);
    assign accept_run = (state == IDLE) && start && !(start_div && divisor_zero);
    assign cnt_load   = accept_run;
    assign cnt_dec    = (state == RUN) && !abort;
    assign cnt_clear  = (state == RUN) && abort;

    contador_ciclos #(
        .W (CNT_W)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (start_div ? DIV_LOAD : MULT_LOAD),
        .dec        (cnt_dec),
        .clear      (cnt_clear),
        .count      (count),
        .zero       (cnt_zero)
    );

    // Sequencer: every output is registered and reflects the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            op_div       <= 1'b0;
            busy         <= 1'b0;
            mult_op      <= 1'b0;
            div_op       <= 1'b0;
            signed_op    <= 1'b0;
            reg_hi_write <= 1'b0;
            reg_lo_write <= 1'b0;
            mux_hi       <= 1'b0;
            mux_lo       <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
        end else begin
            mult_op      <= 1'b0;
            div_op       <= 1'b0;
            reg_hi_write <= 1'b0;
            reg_lo_write <= 1'b0;
            mux_hi       <= 1'b0;
            mux_lo       <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        signed_op <= ~op[0];
                        if (start_div && divisor_zero) begin
                            state        <= EXC;
                            div_zero_exc <= 1'b1;
                        end else begin
                            state   <= RUN;
                            op_div  <= start_div;
                            mult_op <= ~start_div;
                            div_op  <= start_div;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        signed_op <= 1'b0;
                    end else if (cnt_zero) begin
                        state        <= WRITE;
                        reg_hi_write <= 1'b1;
                        reg_lo_write <= 1'b1;
                        done         <= 1'b1;
                        mux_hi       <= op_div;
                        mux_lo       <= op_div;
                    end else begin
                        mult_op <= ~op_div;
                        div_op  <= op_div;
                    end
                end
                WRITE, EXC: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    signed_op <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    signed_op <= 1'b0;
                end
            endcase
        end
    end

endmodule
